inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Assembles LEGv8 instruction words (R, D, CB formats) from field-level requests.
//  Buffers the encoded words in a FIFO and streams them, with sequential word
//  addresses, to the instruction-memory program loader.
//  This is the encode side of the main-decoder opcode map: every word it emits
//  must decode, from Op=instr[31:21], to the intended control vector.
//  Covers LDUR, STUR, CBZ, ADD, SUB, AND, ORR.
// PARAMETERS
//  DEPTH  4   FIFO entries; must be a power of 2, >=2
//  AW     6   output word-address width; address wraps at 2**AW
// PORTS
//  clk        in   1   single clock; all state on posedge
//  reset      in   1   asynchronous, active-high; clears all state
//  clear      in   1   synchronous flush: empties FIFO, out_addr<=0
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid&&req_ready
//  req_op     in   3   legv8_pkg::op_e: LDUR,STUR,CBZ,ADD,SUB,AND,ORR (others illegal)
//  req_rd     in   5   Rd (R-type) / Rt (D, CB)
//  req_rn     in   5   Rn (R, D)
//  req_rm     in   5   Rm (R)
//  req_imm    in   19  signed immediate: D uses low 9 bits, CB uses all 19
//  err        out  1   1-cycle pulse: accepted request was rejected
//  out_valid  out  1   encoded word available
//  out_ready  in   1   sink accepts when out_valid&&out_ready
//  out_data   out  32  encoded instruction word
//  out_addr   out  AW  word address of out_data
// BEHAVIOUR
//  Encoding formats:
//   R:  {opc11, Rm, 6'b0, Rn, Rd}
//       ADD=10001011000, SUB=11001011000, AND=10001010000, ORR=10101010000
//   D:  {opc11, imm[8:0], 2'b00, Rn, Rt}
//       LDUR=11111000010, STUR=11111000000
//   CB: {8'b10110100, imm[18:0], Rt}
//  Reset/clear values:
//   req_ready=1, err=0, out_valid=0, out_data=0, out_addr=0, FIFO empty.
//  Input handshake:
//   - req_ready = !full, driven from registered count only.
//   - No combinational path from out_ready to req_ready: a push while full
//     is refused even when a pop happens in the same cycle.
//  Rejects:
//   - Illegal req_op, or D-type req_imm[18:8] not all equal to req_imm[8]
//     (9-bit signed range violated).
//   - Request is consumed (handshake completes), is not enqueued, and err
//     is asserted the next cycle.
//  Latency: an accepted legal request appears on out_* one cycle after
//   acceptance at the earliest. Order is preserved.
//  Output handshake:
//   - out_valid = !empty; out_data and out_addr are registered.
//   - out_data and out_addr are held stable while out_valid && !out_ready.
//  Address:
//   - out_addr increments on each pop.
//   - Wraps from 2**AW-1 to 0 with no flag.
//  Boundary cases:
//   - Push and pop in the same cycle, not full: count unchanged.
//   - Pop while empty: no effect.
//   - clear has priority over a push or pop in the same cycle; a
//     same-cycle push is dropped and err stays 0.
//   - reset mid-stream: contents lost, outputs return to reset values
//     immediately.
//  Internal state machine: none beyond the FIFO. Write and read pointers
//   are log2(DEPTH)+1 bits wide so full and empty are unambiguous.
// STRUCTURE
//  legv8_pkg:
//   - op_e enum
//   - 11-bit opcode localparams (shared with the main decoder)
//   - CBZ 8-bit prefix
//   - fmt_e {FMT_R, FMT_D, FMT_CB}
//  Sub-module sync_fifo #(WIDTH=32, DEPTH):
//   - push/pop/full/empty/clear
//   - parent holds encode logic and the address counter
// TESTING
//  1 ADD rd=1 rn=2 rm=3 -> out_data=0x8B030041, out_addr=0.
//  2 LDUR rt=9 rn=10 imm=8 -> 0xF8408149.
//    CBZ rt=0 imm=19'h7FFFE -> 0xB4FFFFC0 at addr 1.
//  3 STUR imm=300 -> err=1 for one cycle, nothing enqueued.
//    req_op=7 -> err=1, nothing enqueued.
//  4 out_ready=0, push 4 words -> req_ready=0.
//    Push+pop in the same cycle -> push refused.
//    Drain -> data in order, addrs consecutive.
//  5 Stream 70 words with out_ready=1 -> out_addr wraps 63->0 with no gap.
//  6 Assert clear with 3 queued -> out_valid=0 next cycle, next word at addr 0.
//    Assert reset mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/legv8_pkg.sv
// LEGv8 opcode map shared by the encoder and the main decoder.
// Holds the request op set, 11-bit opcodes and instruction formats.
package legv8_pkg;

  typedef enum logic [2:0] {
    OP_LDUR = 3'd0,
    OP_STUR = 3'd1,
    OP_CBZ  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_AND  = 3'd5,
    OP_ORR  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_D,
    FMT_CB
  } fmt_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  CBZ_PFX  = 8'b10110100;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra pointer MSB to tell full from empty.
// Head entry is presented directly from storage; zero when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW-1] != rd_q[PW-1]) &&
                 (wr_q[IW-1:0] == rd_q[IW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rdata = empty ? '0 : mem_q[rd_q[IW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!clear && do_push) begin
      mem_q[wr_q[IW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Encodes LEGv8 R/D/CB requests and streams them with word addresses
// to the program loader through a small FIFO.
module inst_encoder
  import legv8_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rn,
  input  logic [4:0]    req_rm,
  input  logic [18:0]   req_imm,
  output logic          err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [AW-1:0] out_addr
);

  op_e         op;
  fmt_e        fmt;
  logic [10:0] opc;
  logic [31:0] word;
  logic        legal;
  logic        accept, push, pop;
  logic        full, empty;
  logic        err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;

  assign op = op_e'(req_op);

  always_comb begin
    fmt   = FMT_R;
    opc   = '0;
    legal = 1'b1;
    unique case (op)
      OP_ADD:  opc = OPC_ADD;
      OP_SUB:  opc = OPC_SUB;
      OP_AND:  opc = OPC_AND;
      OP_ORR:  opc = OPC_ORR;
      OP_LDUR: begin fmt = FMT_D; opc = OPC_LDUR; end
      OP_STUR: begin fmt = FMT_D; opc = OPC_STUR; end
      OP_CBZ:  fmt = FMT_CB;
      default: legal = 1'b0;
    endcase
    // D-type offset must fit a 9-bit signed field
    if (fmt == FMT_D && req_imm[18:8] != {11{req_imm[8]}})
      legal = 1'b0;
  end

  always_comb begin
    word = '0;
    unique case (fmt)
      FMT_R:  word = {opc, req_rm, 6'b0, req_rn, req_rd};
      FMT_D:  word = {opc, req_imm[8:0], 2'b00, req_rn, req_rd};
      FMT_CB: word = {CBZ_PFX, req_imm, req_rd};
      default: word = '0;
    endcase
  end

  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && legal && !clear;
  assign pop       = out_ready && !empty;
  assign err_d     = accept && !legal && !clear;

  always_comb begin
    addr_d = addr_q;
    if (clear)    addr_d = '0;
    else if (pop) addr_d = addr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      err_q  <= err_d;
      addr_q <= addr_d;
    end
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .push (push),
    .pop  (pop),
    .wdata(word),
    .rdata(out_data),
    .full (full),
    .empty(empty)
  );

  assign err       = err_q;
  assign out_valid = !empty;
  assign out_addr  = addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, rejects, backpressure,
// address wrap, clear and asynchronous reset.
module tb_inst_encoder;

  localparam int AW = 6;

  localparam logic [2:0] LDUR = 3'd0;
  localparam logic [2:0] STUR = 3'd1;
  localparam logic [2:0] CBZ  = 3'd2;
  localparam logic [2:0] ADD  = 3'd3;
  localparam logic [2:0] ORR  = 3'd6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [4:0]    req_rd = '0;
  logic [4:0]    req_rn = '0;
  logic [4:0]    req_rm = '0;
  logic [18:0]   req_imm = '0;
  logic          err;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;

  int checks = 0;
  int failures = 0;

  inst_encoder #(.DEPTH(4), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_rd   (req_rd),
    .req_rn   (req_rn),
    .req_rm   (req_rm),
    .req_imm  (req_imm),
    .err      (err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] add_w(input logic [4:0] rd,
                                        input logic [4:0] rn,
                                        input logic [4:0] rm);
    return {11'b10001011000, rm, 6'b0, rn, rd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    out_ready = 1'b0;
    clear = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm,
                      input logic [18:0] imm);
    bit done = 0;
    req_op = op; req_rd = rd; req_rn = rn;
    req_rm = rm; req_imm = imm;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req_ready) done = 1;
      step();
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    step();
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_addr",  32'(out_addr), 32'd0);

    // ADD encoding
    send(ADD, 5'd1, 5'd2, 5'd3, 19'd0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_data", out_data, 32'h8B030041);
    chk("add_addr", 32'(out_addr), 32'd0);
    pop_one();
    chk("add_popped", 32'(out_valid), 32'd0);

    // LDUR then CBZ
    do_reset();
    send(LDUR, 5'd9, 5'd10, 5'd0, 19'd8);
    send(CBZ, 5'd0, 5'd0, 5'd0, 19'h7FFFE);
    chk("ldur_data", out_data, 32'hF8408149);
    chk("ldur_addr", 32'(out_addr), 32'd0);
    pop_one();
    chk("cbz_data", out_data, 32'hB4FFFFC0);
    chk("cbz_addr", 32'(out_addr), 32'd1);
    pop_one();
    chk("cbz_empty", 32'(out_valid), 32'd0);

    // Rejects
    send(STUR, 5'd1, 5'd2, 5'd0, 19'd300);
    chk("stur_err", 32'(err), 32'd1);
    chk("stur_noq", 32'(out_valid), 32'd0);
    step();
    chk("stur_err_pulse", 32'(err), 32'd0);
    send(3'd7, 5'd1, 5'd2, 5'd3, 19'd0);
    chk("op7_err", 32'(err), 32'd1);
    chk("op7_noq", 32'(out_valid), 32'd0);
    step();
    chk("op7_err_pulse", 32'(err), 32'd0);
    // Negative D offset in range is legal
    send(STUR, 5'd4, 5'd5, 5'd0, 19'h7FFFF);
    chk("stur_neg_err", 32'(err), 32'd0);
    chk("stur_neg_data", out_data, 32'hF81FF0A4);
    pop_one();

    // Backpressure and full
    do_reset();
    for (int i = 0; i < 4; i++)
      send(ADD, 5'(i), 5'(i + 1), 5'(i + 2), 19'd0);
    chk("full_ready", 32'(req_ready), 32'd0);
    req_op = ADD; req_rd = 5'd31; req_rn = 5'd31; req_rm = 5'd31;
    req_valid = 1'b1;
    out_ready = 1'b1;
    step();
    req_valid = 1'b0;
    out_ready = 1'b0;
    chk("pp_ready", 32'(req_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", out_data, add_w(5'(i), 5'(i + 1), 5'(i + 2)));
      chk("drain_addr", 32'(out_addr), 32'(i));
      pop_one();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Streaming with address wrap
    do_reset();
    out_ready = 1'b1;
    req_op = ADD;
    req_valid = 1'b1;
    for (int k = 0; k < 70; k++) begin
      req_rd = 5'(k); req_rn = 5'(k >> 5); req_rm = 5'd7;
      chk("stream_ready", 32'(req_ready), 32'd1);
      step();
      chk("stream_data", out_data,
          add_w(5'(k), 5'(k >> 5), 5'd7));
      chk("stream_addr", 32'(out_addr), 32'(k % 64));
    end
    req_valid = 1'b0;
    step();
    chk("stream_end_valid", 32'(out_valid), 32'd0);
    chk("stream_end_addr", 32'(out_addr), 32'd6);
    out_ready = 1'b0;

    // Clear with entries queued and a same-cycle push
    do_reset();
    for (int i = 0; i < 4; i++)
      send(ADD, 5'(i), 5'd0, 5'd0, 19'd0);
    pop_one();
    chk("pre_clr_addr", 32'(out_addr), 32'd1);
    req_op = ADD; req_rd = 5'd9;
    req_valid = 1'b1;
    out_ready = 1'b1;
    clear = 1'b1;
    step();
    req_valid = 1'b0;
    out_ready = 1'b0;
    clear = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_addr", 32'(out_addr), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_ready", 32'(req_ready), 32'd1);
    send(ORR, 5'd5, 5'd6, 5'd7, 19'd0);
    chk("orr_data", out_data, 32'hAA0700C5);
    chk("orr_addr", 32'(out_addr), 32'd0);

    // Asynchronous reset mid-stream
    send(ADD, 5'd1, 5'd1, 5'd1, 19'd0);
    pop_one();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_addr", 32'(out_addr), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_err", 32'(err), 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
